// File: rtl/cccd_axil_arbiter.sv
// cccd_axil_arbiter: round-robin arbiter that shares one AXI4-Lite master port
// among NREQ local requesters. Each request is a single-beat read or write. Only
// one AXI transaction is in flight at a time, and its response goes back only to
// the requester that issued it.
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   req_valid/ready/write    per-requester handshake and direction
//   req_addr/req_wdata       packed per-requester address / write data
//   rsp_valid/rdata/resp     one-hot response pulse with read data and AXI resp
//   m_axi_*                  AXI4-Lite master (AW/W/B/AR/R channels)
//   timeout_err              sticky watchdog flag (CCCD_ARB_TIMEOUT_EN only)
//
// Optional feature: define CCCD_ARB_TIMEOUT_EN to enable the watchdog.
// With it enabled, a transaction that runs for TIMEOUT_CYCLES clocks is answered
// with resp=2'b11, and the FSM drains the late AXI completion through the DRAIN state.
module cccd_axil_arbiter #(
   parameter int unsigned NREQ           = 2,
   parameter int unsigned ADDR_W         = 4,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic [1:0]               rsp_resp,
   output logic [ADDR_W-1:0]        m_axi_awaddr,
   output logic [2:0]               m_axi_awprot,
   output logic                     m_axi_awvalid,
   input  logic                     m_axi_awready,
   output logic [DATA_W-1:0]        m_axi_wdata,
   output logic [DATA_W/8-1:0]      m_axi_wstrb,
   output logic                     m_axi_wvalid,
   input  logic                     m_axi_wready,
   input  logic [1:0]               m_axi_bresp,
   input  logic                     m_axi_bvalid,
   output logic                     m_axi_bready,
   output logic [ADDR_W-1:0]        m_axi_araddr,
   output logic [2:0]               m_axi_arprot,
   output logic                     m_axi_arvalid,
   input  logic                     m_axi_arready,
   input  logic [DATA_W-1:0]        m_axi_rdata,
   input  logic [1:0]               m_axi_rresp,
   input  logic                     m_axi_rvalid,
   output logic                     m_axi_rready
`ifdef CCCD_ARB_TIMEOUT_EN
   ,
   output logic                     timeout_err
`endif
);

   localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned STRB_W = DATA_W / 8;

   // Reject parameter sets the design does not support
   if (NREQ < 1 || NREQ > 8 || DATA_W != 32 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("cccd_axil_arbiter: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_RESP,
      RD_ADDR,
      RD_DATA
`ifdef CCCD_ARB_TIMEOUT_EN
      ,
      DRAIN
`endif
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    rr_ptr;
   logic [IDX_W-1:0]    cur_idx;
   logic                cur_write;
   logic [ADDR_W-1:0]   cur_addr;
   logic [DATA_W-1:0]   cur_wdata;

   logic                grant_found;
   logic [IDX_W-1:0]    grant_idx;
   logic                aw_done;
   logic                w_done;

   // Reduce any sum modulo NREQ into a requester index
   function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
      return IDX_W'(v % NREQ);
   endfunction

   // First active requester at or above rr_ptr, wrapping; the lowest offset wins
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[wrap_idx(32'(rr_ptr) + unsigned'(k))]) begin
            grant_found = 1'b1;
            grant_idx   = wrap_idx(32'(rr_ptr) + unsigned'(k));
         end
      end
   end

   // A channel is done once its valid has dropped or is handshaking this cycle
   assign aw_done = !m_axi_awvalid || m_axi_awready;
   assign w_done  = !m_axi_wvalid  || m_axi_wready;

   assign m_axi_awaddr = cur_addr;
   assign m_axi_araddr = cur_addr;
   assign m_axi_wdata  = cur_wdata;
   assign m_axi_wstrb  = {STRB_W{1'b1}};
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;

`ifdef CCCD_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt;
   logic             tmo_hit;

   // Fires on the edge that completes TIMEOUT_CYCLES busy clocks after the grant
   assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // Arbitration and AXI sequencing FSM
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         cur_idx       <= '0;
         cur_write     <= 1'b0;
         cur_addr      <= '0;
         cur_wdata     <= '0;
         req_ready     <= '0;
         rsp_valid     <= '0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
`ifdef CCCD_ARB_TIMEOUT_EN
         tmo_cnt       <= '0;
         timeout_err   <= 1'b0;
`endif
      end else begin
         req_ready <= '0;
         rsp_valid <= '0;
`ifdef CCCD_ARB_TIMEOUT_EN
         if (state == WR || state == WR_RESP || state == RD_ADDR || state == RD_DATA) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end
`endif
         case (state)
            IDLE: begin
               if (grant_found) begin
                  req_ready <= NREQ'(1) << grant_idx;
                  rr_ptr    <= wrap_idx(32'(grant_idx) + 32'd1);
                  cur_idx   <= grant_idx;
                  cur_write <= req_write[grant_idx];
                  cur_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                  cur_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
`ifdef CCCD_ARB_TIMEOUT_EN
                  tmo_cnt   <= '0;
`endif
                  if (req_write[grant_idx]) begin
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     state         <= WR;
                  end else begin
                     m_axi_arvalid <= 1'b1;
                     state         <= RD_ADDR;
                  end
               end
            end
            WR: begin
               if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
               if (aw_done && w_done) begin
                  m_axi_bready <= 1'b1;
                  state        <= WR_RESP;
               end
`ifdef CCCD_ARB_TIMEOUT_EN
               else if (tmo_hit) begin
                  rsp_valid   <= NREQ'(1) << cur_idx;
                  rsp_resp    <= 2'b11;
                  rsp_rdata   <= '0;
                  timeout_err <= 1'b1;
                  state       <= DRAIN;
               end
`endif
            end
            WR_RESP: begin
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  rsp_valid    <= NREQ'(1) << cur_idx;
                  rsp_resp     <= m_axi_bresp;
                  rsp_rdata    <= '0;
                  state        <= IDLE;
               end
`ifdef CCCD_ARB_TIMEOUT_EN
               else if (tmo_hit) begin
                  rsp_valid   <= NREQ'(1) << cur_idx;
                  rsp_resp    <= 2'b11;
                  rsp_rdata   <= '0;
                  timeout_err <= 1'b1;
                  state       <= DRAIN;
               end
`endif
            end
            RD_ADDR: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= RD_DATA;
               end
`ifdef CCCD_ARB_TIMEOUT_EN
               else if (tmo_hit) begin
                  rsp_valid   <= NREQ'(1) << cur_idx;
                  rsp_resp    <= 2'b11;
                  rsp_rdata   <= '0;
                  timeout_err <= 1'b1;
                  state       <= DRAIN;
               end
`endif
            end
            RD_DATA: begin
               if (m_axi_rvalid) begin
                  m_axi_rready <= 1'b0;
                  rsp_valid    <= NREQ'(1) << cur_idx;
                  rsp_resp     <= m_axi_rresp;
                  rsp_rdata    <= m_axi_rdata;
                  state        <= IDLE;
               end
`ifdef CCCD_ARB_TIMEOUT_EN
               else if (tmo_hit) begin
                  rsp_valid   <= NREQ'(1) << cur_idx;
                  rsp_resp    <= 2'b11;
                  rsp_rdata   <= '0;
                  timeout_err <= 1'b1;
                  state       <= DRAIN;
               end
`endif
            end
`ifdef CCCD_ARB_TIMEOUT_EN
            // Finish the abandoned AXI transaction silently, then go idle
            DRAIN: begin
               if (cur_write) begin
                  if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
                  if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
                  if (m_axi_bready && m_axi_bvalid) begin
                     m_axi_bready <= 1'b0;
                     state        <= IDLE;
                  end else if (!m_axi_bready && aw_done && w_done) begin
                     m_axi_bready <= 1'b1;
                  end
               end else begin
                  if (m_axi_arvalid && m_axi_arready) begin
                     m_axi_arvalid <= 1'b0;
                     m_axi_rready  <= 1'b1;
                  end else if (m_axi_rready && m_axi_rvalid) begin
                     m_axi_rready <= 1'b0;
                     state        <= IDLE;
                  end
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cccd_axil_arbiter.sv
// Scoreboard bench for cccd_axil_arbiter with a 4-register AXI4-Lite slave model.
module tb_cccd_axil_arbiter;

   localparam int NREQ = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [1:0]  req_write = '0;
   logic [7:0]  req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
`ifdef CCCD_ARB_TIMEOUT_EN
   logic        timeout_err;
`endif

   always #5 clk = ~clk;

   cccd_axil_arbiter #(.NREQ(NREQ), .ADDR_W(4), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clock(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
      .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
      .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
      .m_axi_rready(rready)
`ifdef CCCD_ARB_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   // ---------------- slave model ----------------
   int          aw_stall = 0;
   bit          ar_block = 1'b0;
   bit          r_hold = 1'b0;
   int          aw_cnt;
   logic [31:0] mem [4];
   logic        aw_got, w_got, rpend;
   logic [3:0]  aw_a, ra;
   logic [31:0] w_d;

   assign awready = awvalid && (aw_cnt >= aw_stall);
   assign wready  = wvalid;
   assign arready = arvalid && !ar_block;
   assign rresp   = 2'b00;

   always @(posedge clk) begin
      if (reset) begin
         bvalid <= 1'b0; rvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
         rpend <= 1'b0; aw_cnt <= 0; bresp <= 2'b00; rdata <= '0;
      end else begin
         if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; aw_cnt <= 0; end
         else if (awvalid) aw_cnt <= aw_cnt + 1;
         if (wvalid && wready) begin w_got <= 1'b1; w_d <= wdata; end
         if (aw_got && w_got && !bvalid) begin
            mem[aw_a[3:2]] <= w_d; bvalid <= 1'b1; bresp <= 2'b00;
            aw_got <= 1'b0; w_got <= 1'b0;
         end
         if (bvalid && bready) bvalid <= 1'b0;
         if (arvalid && arready) begin rpend <= 1'b1; ra <= araddr; end
         if (rpend && !r_hold && !rvalid) begin
            rvalid <= 1'b1; rdata <= mem[ra[3:2]]; rpend <= 1'b0;
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct { int idx; logic [31:0] rdata; logic [1:0] resp; } exp_t;
   exp_t exp_q[$];
   int   gnt_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   grant_cyc = 0;
   int   rsp_cyc = 0;
   int   aw_hi = 0, w_hi = 0, b_hs = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (bvalid && bready) b_hs++;
   end

   // Monitor: compare grants and responses whenever the DUT presents them
   always @(negedge clk) begin
      if (req_ready != 2'b00) begin
         grant_cyc = cyc;
         if (gnt_q.size() == 0) chk("unexpected_grant", 64'(req_ready), 64'd0);
         else begin
            int g;
            logic [1:0] oh;
            g  = gnt_q.pop_front();
            oh = 2'b01 << g;
            chk("grant_onehot", 64'(req_ready), 64'(oh));
         end
      end
      if (rsp_valid != 2'b00) begin
         rsp_cyc = cyc;
         if (exp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
         else begin
            exp_t e;
            logic [1:0] oh;
            e  = exp_q.pop_front();
            oh = 2'b01 << e.idx;
            chk("rsp_dest", 64'(rsp_valid), 64'(oh));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
         end
      end
   end

   task automatic expect_txn(input int idx, input logic [31:0] rd, input logic [1:0] resp);
      exp_t e;
      e.idx = idx; e.rdata = rd; e.resp = resp;
      gnt_q.push_back(idx);
      exp_q.push_back(e);
   endtask

   // Present one request from requester idx and hold it until granted
   task automatic req_txn(input int idx, input bit wr, input logic [3:0] a, input logic [31:0] d);
      int n;
      req_write[idx] = wr;
      req_addr[idx*4 +: 4] = a;
      req_wdata[idx*32 +: 32] = d;
      req_valid[idx] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[idx] && n < 300);
      if (!req_ready[idx]) chk("grant_timeout", 64'd0, 64'd1);
      req_valid[idx] = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || gnt_q.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size() + gnt_q.size()), 64'd0);
   endtask

   initial begin
      int n;
      // Reset for 100 ns
      repeat (10) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_axi_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_rsp_resp", 64'(rsp_resp), 64'd0);
      chk("wstrb_prot", 64'({wstrb, awprot, arprot}), 64'h3C0);
`ifdef CCCD_ARB_TIMEOUT_EN
      chk("rst_timeout_err", 64'(timeout_err), 64'd0);
`endif
      reset = 1'b0;
      @(negedge clk);

      // 1: requester 0 writes four registers then reads them back
      for (int i = 0; i < 4; i++) begin
         expect_txn(0, 32'h0, 2'b00);
         req_txn(0, 1'b1, 4'(i * 4), 32'(i + 1));
      end
      for (int i = 0; i < 4; i++) begin
         expect_txn(0, 32'(i + 1), 2'b00);
         req_txn(0, 1'b0, 4'(i * 4), 32'h0);
      end
      wait_drain();

      // Return rr_ptr to 0
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 2: simultaneous writes, requester 0 wins first
      expect_txn(0, 32'h0, 2'b00);
      expect_txn(1, 32'h0, 2'b00);
      fork
         req_txn(0, 1'b1, 4'h0, 32'hA);
         req_txn(1, 1'b1, 4'h4, 32'hB);
      join
      wait_drain();

      // 3: both hold requests for six transactions, grants alternate
      expect_txn(0, 32'h0,  2'b00);
      expect_txn(1, 32'hB,  2'b00);
      expect_txn(0, 32'h55, 2'b00);
      expect_txn(1, 32'h0,  2'b00);
      expect_txn(0, 32'h77, 2'b00);
      expect_txn(1, 32'hA,  2'b00);
      fork
         begin
            req_txn(0, 1'b1, 4'h8, 32'h55);
            req_txn(0, 1'b0, 4'h8, 32'h0);
            req_txn(0, 1'b0, 4'hC, 32'h0);
         end
         begin
            req_txn(1, 1'b0, 4'h4, 32'h0);
            req_txn(1, 1'b1, 4'hC, 32'h77);
            req_txn(1, 1'b0, 4'h0, 32'h0);
         end
      join
      wait_drain();

      // 4: awready stalls while wready is immediate
      aw_stall = 4;
      aw_hi = 0; w_hi = 0; b_hs = 0;
      expect_txn(0, 32'h0, 2'b00);
      req_txn(0, 1'b1, 4'h0, 32'h99);
      wait_drain();
      chk("stall_awvalid_cycles", 64'(aw_hi), 64'd5);
      chk("stall_wvalid_cycles", 64'(w_hi), 64'd1);
      chk("stall_b_handshakes", 64'(b_hs), 64'd1);
      aw_stall = 0;
      expect_txn(1, 32'h99, 2'b00);
      req_txn(1, 1'b0, 4'h0, 32'h0);
      wait_drain();

      // 5: reset while waiting in RD_DATA aborts with no response
      r_hold = 1'b1;
      gnt_q.push_back(0);
      req_txn(0, 1'b0, 4'h4, 32'h0);
      n = 0;
      while (!rready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rd_data_reached", 64'(rready), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
      chk("midrst_handshake", 64'({req_ready, rsp_valid}), 64'd0);
      reset = 1'b0;
      r_hold = 1'b0;
      repeat (5) @(negedge clk);
      expect_txn(1, 32'hB, 2'b00);
      req_txn(1, 1'b0, 4'h4, 32'h0);
      wait_drain();

`ifdef CCCD_ARB_TIMEOUT_EN
      // 6: arready held low triggers the watchdog; drain gives no second response
      ar_block = 1'b1;
      expect_txn(0, 32'h0, 2'b11);
      req_txn(0, 1'b0, 4'h0, 32'h0);
      wait_drain();
      chk("timeout_latency", 64'(rsp_cyc - grant_cyc), 64'd16);
      chk("timeout_err_set", 64'(timeout_err), 64'd1);
      ar_block = 1'b0;
      repeat (10) @(negedge clk);
      expect_txn(1, 32'h99, 2'b00);
      req_txn(1, 1'b0, 4'h0, 32'h0);
      wait_drain();
      chk("timeout_err_sticky", 64'(timeout_err), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
